// File: rtl/fetch_pkg.sv
// Shared fetch types: XLEN, reset PC, instruction size, FSM states, queue entry.
// No logic; latency and backpressure do not apply.
package fetch_pkg;

  localparam int              XLEN             = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0;
  localparam logic [XLEN-1:0] INST_BYTES       = 32'd4;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~(INST_BYTES - 32'd1);
  endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch bundle: redirect/halt control, imem request/response, IF/ID head port.
// master = fetch queue, slave = pipeline + instruction memory.
interface inst_fetch_queue_if;
  import fetch_pkg::*;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            halt;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_inst;
  logic            if_ready;

  modport master (
    input  redirect_valid, redirect_pc, halt,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, if_ready,
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst
  );

  modport slave (
    output redirect_valid, redirect_pc, halt,
    output imem_req_ready, imem_resp_valid, imem_resp_data, if_ready,
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst
  );

endinterface

// File: rtl/fetch_fifo.sv
// Circular {pc, inst} queue; a push becomes visible at the head one cycle later.
// No internal backpressure: the caller guarantees push never hits a full queue.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t push_dat,
  output fetch_entry_t head_dat,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == DEPTH[CW-1:0]);
  assign do_pop   = pop && (count != '0);
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[head_ptr];

  // Storage is reset too so the head port reads zero straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) begin
        mem[tail_ptr] <= push_dat;
        tail_ptr      <= tail_ptr + PW'(1);
      end
      if (do_pop) begin
        head_ptr <= head_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Sequential instruction fetch into a DEPTH-entry queue; response to if_valid is 1 cycle.
// Requests are credit-limited (queued + in flight < DEPTH), so responses are never refused.
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input logic               clk,
  input logic               rst,
  inst_fetch_queue_if.master bus
);

  localparam int           CW    = $clog2(DEPTH + 1);
  localparam logic [CW:0]  LIMIT = DEPTH[CW:0];

  fetch_state_e    state;
  fetch_state_e    state_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   occupancy;
  logic [CW-1:0]   in_flight_after;
  logic            has_room;
  logic            req_hs;
  logic            resp_accept;
  logic            pop;
  fetch_entry_t    head;

  assign has_room = ({1'b0, occupancy} + {1'b0, outstanding}) < LIMIT;

  // Gated by rst so the request line is low the moment reset is applied.
  assign bus.imem_req_valid = rst && (state == FETCH) && !bus.redirect_valid && has_room;
  assign bus.imem_req_addr  = fetch_pc;
  assign req_hs             = bus.imem_req_valid && bus.imem_req_ready;

  assign resp_accept = bus.imem_resp_valid && !bus.redirect_valid && (drop_cnt == '0);
  assign pop         = bus.if_valid && bus.if_ready && !bus.redirect_valid;

  assign bus.if_valid = (occupancy != '0);
  assign bus.if_pc    = head.pc;
  assign bus.if_inst  = head.inst;

  // Everything still in flight at a redirect (less what lands now) is stale.
  assign in_flight_after = outstanding - CW'(bus.imem_resp_valid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.redirect_valid) begin
      state_nxt = FETCH;
    end else if ((state == FETCH) && bus.halt) begin
      state_nxt = HALTED;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc    <= align_pc(bus.redirect_pc);
      resp_pc     <= align_pc(bus.redirect_pc);
      outstanding <= in_flight_after;
      drop_cnt    <= in_flight_after;
    end else begin
      if (req_hs) begin
        fetch_pc <= fetch_pc + INST_BYTES;
      end
      if (resp_accept) begin
        resp_pc <= resp_pc + INST_BYTES;
      end
      if (bus.imem_resp_valid && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      case ({req_hs, bus.imem_resp_valid})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: ;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (bus.redirect_valid),
    .push     (resp_accept),
    .pop      (pop),
    .push_dat ({resp_pc, bus.imem_resp_data}),
    .head_dat (head),
    .count    (occupancy)
  );

endmodule
